// File: rtl/t00_gpio_event_encoder_pkg.sv
// ---------------------------------------------------------------------------
// t00_gpio_pkg
//   Shared constants, types and helpers for the GPIO event encoder.
//   NUM_GPIO      : number of monitored pins (pin k reports index k+1)
//   GPIO_IDX_W    : width of the reported index
//   GPIO_IDX_NONE : index value meaning "no event"
//   lowest_idx()  : 1-based position of the lowest set bit, 0 if none
//   lowest_bit()  : one-hot isolation of the lowest set bit
// ---------------------------------------------------------------------------
package t00_gpio_pkg;

   localparam int NUM_GPIO   = 34;
   localparam int GPIO_IDX_W = 6;
   localparam int WARM_CNT_W = 2;

   typedef logic [NUM_GPIO-1:0]   gpio_vec_t;
   typedef logic [GPIO_IDX_W-1:0] gpio_idx_t;

   localparam gpio_idx_t GPIO_IDX_NONE = '0;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } gpio_enc_state_t;

   // Scan from the top down so the last hit is the lowest pin; the result
   // never exceeds NUM_GPIO.
   function automatic gpio_idx_t lowest_idx(input gpio_vec_t vec);
      gpio_idx_t idx;
      idx = GPIO_IDX_NONE;
      for (int i = NUM_GPIO - 1; i >= 0; i--) begin
         if (vec[i]) idx = gpio_idx_t'(i + 1);
      end
      return idx;
   endfunction

   // Two's-complement trick: vec & -vec keeps only the lowest set bit.
   function automatic gpio_vec_t lowest_bit(input gpio_vec_t vec);
      return vec & (~vec + gpio_vec_t'(1));
   endfunction

endpackage

// File: rtl/t00_gpio_event_encoder_if.sv
// ---------------------------------------------------------------------------
// t00_gpio_event_encoder_if
//   Valid/ready event channel from the encoder to the event/IRQ consumer.
//   idx_out   : 1-based pin index, 0 when no event is offered
//   idx_valid : idx_out holds an unconsumed event
//   idx_ready : consumer takes idx_out this cycle
//   master = encoder side, slave = consumer side.
// ---------------------------------------------------------------------------
interface t00_gpio_event_encoder_if;
   import t00_gpio_pkg::*;

   gpio_idx_t idx_out;
   logic      idx_valid;
   logic      idx_ready;

   modport master (
      output idx_out,
      output idx_valid,
      input  idx_ready
   );

   modport slave (
      input  idx_out,
      input  idx_valid,
      output idx_ready
   );

endinterface

// File: rtl/t00_gpio_event_encoder_edge_sync.sv
// ---------------------------------------------------------------------------
// t00_gpio_edge_sync
//   Three-flop synchronizer on every pin, post-reset warm-up counter and
//   qualified rising-edge vector.
//   clk, rst  : system clock, synchronous active-high reset
//   en        : 1 = report edges, 0 = drop them (chain keeps running)
//   gpio_in   : raw asynchronous pin levels
//   irq_mask  : per-pin edge enable
//   edge_vec  : one-cycle pulse per qualified rising edge
// ---------------------------------------------------------------------------
module t00_gpio_edge_sync
   import t00_gpio_pkg::*;
(
   input  logic      clk,
   input  logic      rst,
   input  logic      en,
   input  gpio_vec_t gpio_in,
   input  gpio_vec_t irq_mask,
   output gpio_vec_t edge_vec
);

   gpio_vec_t             s1, s2, s3;
   logic [WARM_CNT_W-1:0] warm_cnt;
   logic                  armed;

   localparam logic [WARM_CNT_W-1:0] WARM_MAX = '1;

   // s1/s2 form the metastability guard; s3 is the previous s2 for edges.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1       <= '0;
         s2       <= '0;
         s3       <= '0;
         warm_cnt <= '0;
      end else begin
         s1 <= gpio_in;
         s2 <= s1;
         s3 <= s2;
         if (warm_cnt != WARM_MAX) warm_cnt <= warm_cnt + 1'b1;
      end
   end

   // The chain restarts from zero after reset, so a pin held high through
   // reset looks like a rise; staying unarmed until the chain has refilled
   // masks that false edge.
   assign armed    = (warm_cnt == WARM_MAX);
   assign edge_vec = s2 & ~s3 & {NUM_GPIO{armed & en}} & irq_mask;

endmodule

// File: rtl/t00_gpio_event_encoder.sv
// ---------------------------------------------------------------------------
// t00_gpio_event_encoder
//   Latches rising edges on NUM_GPIO pins as pending events and reports them
//   one per handshake as a 1-based pin index, lowest pin first.
//   clk, rst     : system clock, synchronous active-high reset
//   en           : 1 = capture new edges
//   gpio_in      : raw asynchronous pin levels
//   irq_mask     : 1 = pin's rising edge is captured
//   clr_overflow : single-cycle pulse clearing overflow
//   evt          : valid/ready index channel (master side)
//   pending      : latched events not yet loaded into idx_out
//   overflow     : sticky, an edge hit a pin that was still pending
// ---------------------------------------------------------------------------
module t00_gpio_event_encoder
   import t00_gpio_pkg::*;
(
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             en,
   input  gpio_vec_t                        gpio_in,
   input  gpio_vec_t                        irq_mask,
   input  logic                             clr_overflow,
   t00_gpio_event_encoder_if.master         evt,
   output gpio_vec_t                        pending,
   output logic                             overflow
);

   gpio_vec_t       edge_vec;
   gpio_vec_t       pending_q, pending_d;
   gpio_vec_t       pop_bit;
   gpio_enc_state_t state_q, state_d;
   gpio_idx_t       idx_q, idx_d;
   logic            ovf_q, ovf_d, ovf_set;

   t00_gpio_edge_sync u_edge_sync (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .gpio_in  (gpio_in),
      .irq_mask (irq_mask),
      .edge_vec (edge_vec)
   );

   // Handshake FSM. An index is loaded (and its pending bit popped) whenever
   // the output slot is empty or being consumed this cycle, which gives one
   // event per cycle when the consumer keeps ready high.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      pop_bit = '0;
      case (state_q)
         EMPTY: begin
            if (|pending_q) begin
               state_d = FULL;
               idx_d   = lowest_idx(pending_q);
               pop_bit = lowest_bit(pending_q);
            end
         end
         FULL: begin
            if (evt.idx_ready) begin
               if (|pending_q) begin
                  idx_d   = lowest_idx(pending_q);
                  pop_bit = lowest_bit(pending_q);
               end else begin
                  state_d = EMPTY;
                  idx_d   = GPIO_IDX_NONE;
               end
            end
         end
      endcase
   end

   // OR-ing the edge after the pop lets a fresh edge survive a same-cycle
   // pop of that pin. An edge on a pin that stays pending is lost -> overflow.
   always_comb begin
      pending_d = (pending_q & ~pop_bit) | edge_vec;
      ovf_set   = |(edge_vec & pending_q & ~pop_bit);
      ovf_d     = ovf_set | (ovf_q & ~clr_overflow);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= EMPTY;
         idx_q     <= GPIO_IDX_NONE;
         pending_q <= '0;
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         pending_q <= pending_d;
         ovf_q     <= ovf_d;
      end
   end

   assign evt.idx_out   = idx_q;
   assign evt.idx_valid = (state_q == FULL);
   assign pending       = pending_q;
   assign overflow      = ovf_q;

endmodule

// File: tb/tb_t00_gpio_event_encoder.sv
// Directed bench for t00_gpio_event_encoder. Inputs change 1 ns after a
// rising edge; outputs are sampled at that same point.
module tb_t00_gpio_event_encoder;
   import t00_gpio_pkg::*;

   logic      clk;
   logic      rst;
   logic      en;
   gpio_vec_t gpio_in;
   gpio_vec_t irq_mask;
   logic      clr_overflow;
   gpio_vec_t pending;
   logic      overflow;

   int n_chk = 0;
   int n_err = 0;

   t00_gpio_event_encoder_if evt ();

   t00_gpio_event_encoder dut (
      .clk          (clk),
      .rst          (rst),
      .en           (en),
      .gpio_in      (gpio_in),
      .irq_mask     (irq_mask),
      .clr_overflow (clr_overflow),
      .evt          (evt),
      .pending      (pending),
      .overflow     (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] bit_of(input int k);
      gpio_vec_t v;
      v = '0;
      v[k] = 1'b1;
      return 64'(v);
   endfunction

   initial begin
      rst           = 1'b1;
      en            = 1'b1;
      gpio_in       = '1;
      irq_mask      = '0;
      clr_overflow  = 1'b0;
      evt.idx_ready = 1'b0;
      tick(3);
      chk("rst_valid",    64'(evt.idx_valid), 64'd0);
      chk("rst_idx",      64'(evt.idx_out),   64'd0);
      chk("rst_pending",  64'(pending),       64'd0);
      chk("rst_overflow", 64'(overflow),      64'd0);

      // 1: pins high through reset give no event
      rst = 1'b0;
      tick(10);
      chk("t1_valid",   64'(evt.idx_valid), 64'd0);
      chk("t1_pending", 64'(pending),       64'd0);

      // 2: single rise on bit0, then bit33
      irq_mask      = '1;
      evt.idx_ready = 1'b1;
      gpio_in       = '0;
      tick(4);
      gpio_in[0] = 1'b1;
      tick(3);
      chk("t2_e3_pending", 64'(pending),       bit_of(0));
      chk("t2_e3_valid",   64'(evt.idx_valid), 64'd0);
      tick();
      chk("t2_e4_valid",   64'(evt.idx_valid), 64'd1);
      chk("t2_e4_idx",     64'(evt.idx_out),   64'd1);
      chk("t2_e4_pending", 64'(pending),       64'd0);
      tick();
      chk("t2_e5_valid",   64'(evt.idx_valid), 64'd0);
      chk("t2_e5_idx",     64'(evt.idx_out),   64'd0);
      gpio_in[33] = 1'b1;
      tick(4);
      chk("t2_b33_valid",  64'(evt.idx_valid), 64'd1);
      chk("t2_b33_idx",    64'(evt.idx_out),   64'd34);
      tick();
      chk("t2_b33_drain",  64'(evt.idx_valid), 64'd0);

      // 3: two simultaneous rises, lowest first, held while not ready
      evt.idx_ready = 1'b0;
      gpio_in[4] = 1'b1;
      gpio_in[9] = 1'b1;
      tick(3);
      chk("t3_e3_pending", 64'(pending), bit_of(4) | bit_of(9));
      tick();
      chk("t3_idx5",       64'(evt.idx_out), 64'd5);
      chk("t3_pend9",      64'(pending),     bit_of(9));
      tick(2);
      chk("t3_hold_idx",   64'(evt.idx_out),   64'd5);
      chk("t3_hold_valid", 64'(evt.idx_valid), 64'd1);
      evt.idx_ready = 1'b1;
      tick();
      evt.idx_ready = 1'b0;
      chk("t3_idx10",      64'(evt.idx_out), 64'd10);
      chk("t3_pend0",      64'(pending),     64'd0);
      tick();
      chk("t3_hold10",     64'(evt.idx_out), 64'd10);
      evt.idx_ready = 1'b1;
      tick();
      evt.idx_ready = 1'b0;
      chk("t3_empty_valid", 64'(evt.idx_valid), 64'd0);
      chk("t3_empty_idx",   64'(evt.idx_out),   64'd0);

      // 4: masked pin and disabled capture
      irq_mask[2] = 1'b0;
      gpio_in[2]  = 1'b1;
      tick(5);
      chk("t4_mask_valid",   64'(evt.idx_valid), 64'd0);
      chk("t4_mask_pending", 64'(pending),       64'd0);
      irq_mask[2] = 1'b1;
      en          = 1'b0;
      gpio_in[3]  = 1'b1;
      tick(5);
      chk("t4_en_valid",   64'(evt.idx_valid), 64'd0);
      chk("t4_en_pending", 64'(pending),       64'd0);
      en = 1'b1;
      tick(3);
      chk("t4_reen_pending", 64'(pending), 64'd0);

      // 5: repeated pulses on bit7 while the first is unconsumed
      gpio_in[7] = 1'b1; tick();
      gpio_in[7] = 1'b0; tick();
      gpio_in[7] = 1'b1; tick();
      gpio_in[7] = 1'b0; tick();
      gpio_in[7] = 1'b1; tick();
      tick(3);
      chk("t5_idx",      64'(evt.idx_out), 64'd8);
      chk("t5_pending",  64'(pending),     bit_of(7));
      chk("t5_overflow", 64'(overflow),    64'd1);
      clr_overflow = 1'b1;
      tick();
      clr_overflow = 1'b0;
      chk("t5_clr_ovf",  64'(overflow),    64'd0);
      chk("t5_clr_idx",  64'(evt.idx_out), 64'd8);
      evt.idx_ready = 1'b1;
      tick();
      evt.idx_ready = 1'b0;
      chk("t5_again_idx",   64'(evt.idx_out),   64'd8);
      chk("t5_again_valid", 64'(evt.idx_valid), 64'd1);
      chk("t5_again_pend",  64'(pending),       64'd0);
      evt.idx_ready = 1'b1;
      tick();
      evt.idx_ready = 1'b0;
      chk("t5_drain_valid", 64'(evt.idx_valid), 64'd0);

      // 6: reset while an event is offered and another is pending
      gpio_in[10] = 1'b1;
      gpio_in[11] = 1'b1;
      tick(4);
      chk("t6_pre_idx",  64'(evt.idx_out), 64'd11);
      chk("t6_pre_pend", 64'(pending),     bit_of(11));
      rst         = 1'b1;
      gpio_in[12] = 1'b1;
      tick();
      chk("t6_rst_valid", 64'(evt.idx_valid), 64'd0);
      chk("t6_rst_idx",   64'(evt.idx_out),   64'd0);
      chk("t6_rst_pend",  64'(pending),       64'd0);
      chk("t6_rst_ovf",   64'(overflow),      64'd0);
      rst = 1'b0;
      tick(10);
      chk("t6_post_valid", 64'(evt.idx_valid), 64'd0);
      chk("t6_post_pend",  64'(pending),       64'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
